count_load_seq: RTL and testbench

//  Upstream load sequencer for the 4-bit loadable up-counter.
//  - On a start request, issues a series of one-cycle load pulses to the counter:

---
 rtl/count_load_seq_pkg.sv | 20 ++
 rtl/count_load_seq_if.sv | 26 ++
 rtl/count_load_seq_timeout.sv | 35 +++
 rtl/count_load_seq.sv | 101 ++++++++++
 tb/tb_count_load_seq.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/count_load_seq_pkg.sv
// Shared types and constants for the count_load_seq load sequencer.
package count_load_seq_pkg;

  localparam int CNT_W  = 4;
  localparam int ITER_W = 4;

  localparam logic [CNT_W-1:0] TERM_CNT = '1;

  // The watchdog must hold the value 2^CNT_W, so it needs one extra bit.
  localparam int               WD_W     = CNT_W + 1;
  localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(2 ** CNT_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/count_load_seq_if.sv
// Controller/counter-facing signal bundle of the load sequencer.
interface count_load_seq_if;
  import count_load_seq_pkg::*;

  logic              start_i;
  logic [CNT_W-1:0]  start_val_i;
  logic [CNT_W-1:0]  step_i;
  logic [ITER_W-1:0] num_loads_i;
  logic [CNT_W-1:0]  count_i;
  logic              load_o;
  logic [CNT_W-1:0]  load_val_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  modport master (
    output start_i, start_val_i, step_i, num_loads_i, count_i,
    input  load_o, load_val_o, busy_o, done_o, err_o
  );

  modport slave (
    input  start_i, start_val_i, step_i, num_loads_i, count_i,
    output load_o, load_val_o, busy_o, done_o, err_o
  );

endinterface

// File: rtl/count_load_seq_timeout.sv
// Watchdog for WAIT: counts enabled cycles from a cleared start and flags the
// 2^CNT_W+1-th cycle. Only instantiated when TIMEOUT_EN is defined.
module seq_timeout
  import count_load_seq_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != WD_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = en && (cnt_q == WD_LIMIT);

endmodule

// File: rtl/count_load_seq.sv
// Load sequencer: issues num_loads load strobes (start, start+step, ...) to a
// loadable up-counter, each after terminal count. Optional watchdog: TIMEOUT_EN.
module count_load_seq
  import count_load_seq_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  count_load_seq_if.slave  bus
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cur_val_q, cur_val_d;
  logic [CNT_W-1:0]  step_q, step_d;
  logic [ITER_W-1:0] rem_q, rem_d;
  logic              load_q, busy_q, done_q, err_q;
  logic              timeout;
  logic              timed_out;

`ifdef TIMEOUT_EN
  // Held clear outside WAIT, so the first WAIT cycle always starts from zero.
  seq_timeout u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clr     (state_q != WAIT),
    .en      (state_q == WAIT),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cur_val_d = cur_val_q;
    step_d    = step_q;
    rem_d     = rem_q;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          if (bus.num_loads_i != '0) begin
            cur_val_d = bus.start_val_i;
            step_d    = bus.step_i;
            rem_d     = bus.num_loads_i;
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: state_d = WAIT;
      WAIT: begin
        // Terminal count wins over a watchdog expiring in the same cycle.
        if (bus.count_i == TERM_CNT) begin
          if (rem_q == ITER_W'(1)) begin
            state_d = DONE;
          end else begin
            rem_d     = rem_q - 1'b1;
            cur_val_d = cur_val_q + step_q;
            state_d   = LOAD;
          end
        end else if (timeout) begin
          timed_out = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cur_val_q <= '0;
      step_q    <= '0;
      rem_q     <= '0;
      load_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_val_q <= cur_val_d;
      step_q    <= step_d;
      rem_q     <= rem_d;
      load_q    <= (state_d == LOAD);
      busy_q    <= (state_d == LOAD) || (state_d == WAIT);
      done_q    <= (state_d == DONE);
      err_q     <= timed_out;
    end
  end

  assign bus.load_o     = load_q;
  assign bus.load_val_o = load_q ? cur_val_q : '0;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.err_o      = err_q;

endmodule

// File: tb/tb_count_load_seq.sv
// Bench for count_load_seq: a cycle-level expectation queue built from the
// sequencing rules, driven through a 4-bit loadable counter model.
module tb_count_load_seq;
  import count_load_seq_pkg::*;

  typedef struct packed {
    logic             load;
    logic [CNT_W-1:0] val;
    logic             busy;
    logic             done;
    logic             err;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             force_zero = 1'b0;
  logic [CNT_W-1:0] cnt_model = '0;

  exp_t             exp_q[$];
  int               passed = 0;
  int               total = 0;
  int               cyc = 0;
  int               acc_cyc[$];
  int               load_cyc[$];
  logic [CNT_W-1:0] load_vals[$];
  int               done_cyc[$];
  logic             err_at_done[$];

  count_load_seq_if bus();

  count_load_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // The counter being sequenced: loads on load_o, otherwise counts up and wraps.
  always @(posedge clk) cnt_model <= bus.load_o ? bus.load_val_o : cnt_model + 1'b1;
  assign bus.count_i = force_zero ? '0 : cnt_model;

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  function automatic exp_t mk(logic ld, logic [CNT_W-1:0] v, logic b, logic d, logic e);
    exp_t x;
    x.load = ld; x.val = v; x.busy = b; x.done = d; x.err = e;
    return x;
  endfunction

  // Expected outputs for the cycles following an accepted start.
  task automatic plan_sequence(logic [CNT_W-1:0] sv, logic [CNT_W-1:0] st, logic [ITER_W-1:0] n);
    int v;
    if (n == 0) begin
      exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b0));
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      v = (int'(sv) + k * int'(st)) % (2 ** CNT_W);
      exp_q.push_back(mk(1'b1, CNT_W'(v), 1'b1, 1'b0, 1'b0));
      if (force_zero) begin
`ifdef TIMEOUT_EN
        repeat (2 ** CNT_W + 1) exp_q.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b1));
`else
        repeat (64) exp_q.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0));
`endif
        return;
      end
      repeat ((2 ** CNT_W) - v) exp_q.push_back(mk(1'b0, '0, 1'b1, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b1, 1'b0));
  endtask

  // Every-cycle comparison against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] act_v, exp_v;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      e = mk(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end else begin
      e = mk(1'b0, '0, 1'b0, 1'b0, 1'b0);
      if (bus.start_i) begin
        acc_cyc.push_back(cyc);
        plan_sequence(bus.start_val_i, bus.step_i, bus.num_loads_i);
      end
    end
    if (bus.load_o) begin
      load_cyc.push_back(cyc);
      load_vals.push_back(bus.load_val_o);
    end
    if (bus.done_o) begin
      done_cyc.push_back(cyc);
      err_at_done.push_back(bus.err_o);
    end
    act_v = {bus.load_o, e.load ? bus.load_val_o : 4'h0, bus.busy_o, bus.done_o, bus.err_o};
    exp_v = {e.load, e.load ? e.val : 4'h0, e.busy, e.done, e.err};
    checkOutput($sformatf("cycle%0d {load,val,busy,done,err}", cyc), {24'd0, act_v}, {24'd0, exp_v});
  end

  task automatic clear_logs();
    acc_cyc.delete(); load_cyc.delete(); load_vals.delete();
    done_cyc.delete(); err_at_done.delete();
  endtask

  function automatic int rel_load(int i);
    if (i < load_cyc.size() && acc_cyc.size() > 0) return load_cyc[i] - acc_cyc[0];
    return -1000;
  endfunction

  function automatic int rel_done(int i);
    if (i < done_cyc.size() && acc_cyc.size() > 0) return done_cyc[i] - acc_cyc[0];
    return -1000;
  endfunction

  function automatic logic [CNT_W-1:0] val_at(int i);
    if (i < load_vals.size()) return load_vals[i];
    return 'x;
  endfunction

  task automatic applyStimulus(logic [CNT_W-1:0] sv, logic [CNT_W-1:0] st, logic [ITER_W-1:0] n);
    bus.start_val_i = sv; bus.step_i = st; bus.num_loads_i = n; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
  endtask

  task automatic waitIdle(int max_cycles);
    int n = 0;
    while ((exp_q.size() > 0 || bus.busy_o || bus.done_o) && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("idle_reached", {31'd0, (exp_q.size() == 0 && !bus.busy_o && !bus.done_o)}, 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit");
  end

  initial begin
    bus.start_i = 1'b0; bus.start_val_i = '0; bus.step_i = '0; bus.num_loads_i = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {27'd0, bus.load_o, bus.busy_o, bus.done_o, bus.err_o, 1'b0}, 32'd0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Three loads 0,3,6 from a wrapping counter.
    clear_logs();
    applyStimulus(4'h0, 4'h3, 4'd3);
    waitIdle(100);
    checkOutput("t1_load_count", load_cyc.size(), 3);
    checkOutput("t1_load0_cyc", rel_load(0), 1);
    checkOutput("t1_load1_cyc", rel_load(1), 18);
    checkOutput("t1_load2_cyc", rel_load(2), 32);
    checkOutput("t1_vals", {20'd0, val_at(0), val_at(1), val_at(2)}, 32'h036);
    checkOutput("t1_done_cyc", rel_done(0), 43);

    // Zero loads: immediate done, never busy.
    clear_logs();
    applyStimulus(4'h7, 4'h1, 4'd0);
    waitIdle(10);
    checkOutput("t2_load_count", load_cyc.size(), 0);
    checkOutput("t2_done_cyc", rel_done(0), 1);

    // Start at F, step 1: second value wraps to 0.
    clear_logs();
    applyStimulus(4'hF, 4'h1, 4'd2);
    waitIdle(60);
    checkOutput("t3_load1_cyc", rel_load(1), 3);
    checkOutput("t3_vals", {24'd0, val_at(0), val_at(1)}, 32'hF0);
    checkOutput("t3_done_cyc", rel_done(0), 20);

    // Reset during the second WAIT aborts without a done pulse.
    clear_logs();
    applyStimulus(4'h0, 4'h3, 4'd3);
    repeat (19) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checkOutput("t4_async_clear", {28'd0, bus.load_o, bus.busy_o, bus.done_o, bus.err_o}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("t4_no_done", done_cyc.size(), 0);
    clear_logs();
    applyStimulus(4'h5, 4'h2, 4'd1);
    waitIdle(40);
    checkOutput("t4_fresh_val", {28'd0, val_at(0)}, 32'h5);
    checkOutput("t4_fresh_done", rel_done(0), 13);

    // start held high: the restart only happens from the IDLE cycle after DONE.
    clear_logs();
    bus.start_val_i = 4'hC; bus.step_i = 4'h1; bus.num_loads_i = 4'd2; bus.start_i = 1'b1;
    repeat (13) @(posedge clk);
    #1 bus.start_i = 1'b0;
    waitIdle(60);
    checkOutput("t5_accepts", acc_cyc.size(), 2);
    checkOutput("t5_restart_gap", (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 11);
    checkOutput("t5_first_done", rel_done(0), 10);

    // Counter stuck at zero: watchdog ends the sequence, or it hangs busy.
    clear_logs();
    force_zero = 1'b1;
    applyStimulus(4'h5, 4'h0, 4'd1);
`ifdef TIMEOUT_EN
    waitIdle(60);
    checkOutput("t6_timeout_done", rel_done(0), 19);
    checkOutput("t6_err", {31'd0, (err_at_done.size() > 0) ? err_at_done[0] : 1'b0}, 32'd1);
    force_zero = 1'b0;
`else
    repeat (40) @(posedge clk);
    #1;
    checkOutput("t6_hang_busy", {31'd0, bus.busy_o}, 32'd1);
    checkOutput("t6_no_done", done_cyc.size(), 0);
    force_zero = 1'b0;
    pulse_reset();
`endif

    // Normal operation after the stuck-counter episode.
    clear_logs();
    applyStimulus(4'h3, 4'h4, 4'd2);
    waitIdle(60);
    checkOutput("t7_vals", {24'd0, val_at(0), val_at(1)}, 32'h37);
    checkOutput("t7_done_cyc", rel_done(0), 25);

    repeat (3) @(posedge clk);
    $display("[TB] %0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
